// File: rtl/sort_dma_ctrl_pkg.sv
// Shared definitions for the sorter DMA sequencer: FSM states, CSR offsets
// and bit positions inside the CTRL and STATUS registers.
package sort_dma_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SORT  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] CSR_CTRL   = 4'h0;
    localparam logic [3:0] CSR_STATUS = 4'h4;
    localparam logic [3:0] CSR_SRC    = 4'h8;
    localparam logic [3:0] CSR_CYCLES = 4'hC;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR_DONE = 1;
    localparam int CTRL_DST_LSB  = 16;

endpackage

// File: rtl/sort_dma_ctrl.sv
// Sorter DMA sequencer: fetches LIST_LEN words from SRC, presents them to the
// external combinational sorter, captures the sorted list and writes it to DST.
// A small CSR block starts runs and reports busy/done/err plus the run length.
module sort_dma_ctrl
    import sort_dma_ctrl_pkg::*;
#(
    parameter int LIST_LEN  = 8,
    parameter int DAT_WIDTH = 32,
    parameter int ADR_WIDTH = 10,
    parameter int SORT_LAT  = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          csr_req_i,
    output logic                          csr_ack_o,
    input  logic                          csr_we_i,
    input  logic [3:0]                    csr_addr_i,
    input  logic [31:0]                   csr_wdata_i,
    output logic                          csr_resp_o,
    output logic [31:0]                   csr_rdata_o,
    output logic [ADR_WIDTH-1:0]          mem_addr_o,
    output logic                          mem_we_o,
    output logic [DAT_WIDTH-1:0]          mem_wdata_o,
    input  logic [DAT_WIDTH-1:0]          mem_rdata_i,
    output logic [LIST_LEN*DAT_WIDTH-1:0] unsorted_o,
    input  logic [LIST_LEN*DAT_WIDTH-1:0] sorted_i
);

    localparam int CNT_W = 8;
    localparam int IDX_W = (LIST_LEN > 1) ? $clog2(LIST_LEN) : 1;

    localparam logic [CNT_W-1:0]   LEN_C    = CNT_W'(LIST_LEN);
    localparam logic [CNT_W-1:0]   LEN_LAST = CNT_W'(LIST_LEN - 1);
    localparam logic [CNT_W-1:0]   LAT_LAST = CNT_W'(SORT_LAT - 1);
    localparam logic [ADR_WIDTH:0] SPAN     = {1'b1, {ADR_WIDTH{1'b0}}};
    localparam logic [ADR_WIDTH:0] LEN_A    = (ADR_WIDTH+1)'(LIST_LEN);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADR_WIDTH-1:0] src_q;
    logic [ADR_WIDTH-1:0] run_src_q;
    logic [ADR_WIDTH-1:0] run_dst_q;
    logic                 err_q;
    logic [31:0]          cycles_q;
    logic                 resp_q;
    logic [31:0]          rdata_q;
    logic [31:0]          rd_val;
    logic [DAT_WIDTH-1:0] slot_q   [LIST_LEN];
    logic [DAT_WIDTH-1:0] result_q [LIST_LEN];

    logic                 busy;
    logic                 is_done;
    logic                 ctrl_wr;
    logic                 src_wr;
    logic                 csr_rd;
    logic                 start_req;
    logic                 clr_done;
    logic                 start_go;
    logic                 range_ok;
    logic [ADR_WIDTH-1:0] dst_new;
    logic [ADR_WIDTH:0]   src_end;
    logic [ADR_WIDTH:0]   dst_end;
    logic                 unused_wdata;

    assign busy      = (state_q == LOAD) || (state_q == SORT) || (state_q == STORE);
    assign is_done   = (state_q == DONE);
    assign ctrl_wr   = csr_req_i && csr_we_i && (csr_addr_i == CSR_CTRL);
    assign src_wr    = csr_req_i && csr_we_i && (csr_addr_i == CSR_SRC);
    assign csr_rd    = csr_req_i && !csr_we_i;
    assign start_req = ctrl_wr && csr_wdata_i[CTRL_START];
    assign clr_done  = ctrl_wr && csr_wdata_i[CTRL_CLR_DONE];
    assign dst_new   = csr_wdata_i[CTRL_DST_LSB +: ADR_WIDTH];

    // A window must end at or below the top of memory so that the
    // ADR_WIDTH-bit address arithmetic during the run can never wrap.
    assign src_end   = {1'b0, src_q} + LEN_A;
    assign dst_end   = {1'b0, dst_new} + LEN_A;
    assign range_ok  = (src_end <= SPAN) && (dst_end <= SPAN);
    assign start_go  = start_req && (state_q == IDLE || state_q == DONE) && range_ok;

    assign unused_wdata = ^csr_wdata_i;

    assign csr_ack_o   = csr_req_i;
    assign csr_resp_o  = resp_q;
    assign csr_rdata_o = rdata_q;

    // State and phase counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and memory port drive for the current phase.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        case (state_q)
            IDLE: begin
                if (start_go) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                // The extra final cycle only collects the last read word.
                if (cnt_q != LEN_C) begin
                    mem_addr_o = run_src_q + ADR_WIDTH'(cnt_q);
                end
                if (cnt_q == LEN_C) begin
                    state_d = SORT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SORT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = STORE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            STORE: begin
                mem_addr_o  = run_dst_q + ADR_WIDTH'(cnt_q);
                mem_we_o    = 1'b1;
                mem_wdata_o = result_q[cnt_q[IDX_W-1:0]];
                if (cnt_q == LEN_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                if (start_go) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else if (clr_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // CSR state: SRC, the addresses latched for the run, error flag, run length.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q     <= '0;
            run_src_q <= '0;
            run_dst_q <= '0;
            err_q     <= 1'b0;
            cycles_q  <= '0;
        end else begin
            if (src_wr && !busy) begin
                src_q <= csr_wdata_i[ADR_WIDTH-1:0];
            end
            if (start_go) begin
                run_src_q <= src_q;
                run_dst_q <= dst_new;
                err_q     <= 1'b0;
                cycles_q  <= '0;
            end else if (start_req) begin
                err_q <= 1'b1;
            end
            if (busy) begin
                cycles_q <= cycles_q + 32'd1;
            end
        end
    end

    // Read data selection from the register state seen by the request.
    always_comb begin
        rd_val = '0;
        case (csr_addr_i)
            CSR_STATUS: begin
                rd_val[STAT_BUSY] = busy;
                rd_val[STAT_DONE] = is_done;
                rd_val[STAT_ERR]  = err_q;
            end
            CSR_SRC:    rd_val[ADR_WIDTH-1:0] = src_q;
            CSR_CYCLES: rd_val = cycles_q;
            default:    rd_val = '0;
        endcase
    end

    // Read response one cycle after an accepted read; writes never respond.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            resp_q  <= csr_rd;
            rdata_q <= csr_rd ? rd_val : 32'd0;
        end
    end

    generate
        for (genvar gi = 0; gi < LIST_LEN; gi++) begin : g_slot
            // Slot gi takes the read data returning one cycle after address SRC+gi.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    slot_q[gi] <= '0;
                end else if (state_q == LOAD && cnt_q == CNT_W'(gi + 1)) begin
                    slot_q[gi] <= mem_rdata_i;
                end
            end

            // Result gi is captured from the sorter once its settle time has elapsed.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    result_q[gi] <= '0;
                end else if (state_q == SORT && cnt_q == LAT_LAST) begin
                    result_q[gi] <= sorted_i[gi*DAT_WIDTH +: DAT_WIDTH];
                end
            end

            assign unsorted_o[gi*DAT_WIDTH +: DAT_WIDTH] = slot_q[gi];
        end
    endgenerate

endmodule
